// File: rtl/gcd_result_display.sv
// Captures the processor result on a Halt rising edge and converts it to BCD with a serial
// double-dabble engine. Drives a multiplexed three-digit seven-segment display with leading-zero blanking.
module gcd_result_display #(
    parameter int SCAN_CYCLES = 50000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Halt,
    input  logic [7:0]  Result,
    output logic [11:0] Bcd,
    output logic        Valid,
    output logic        Busy,
    output logic [6:0]  Seg,
    output logic [2:0]  DigitEn,
    output logic [1:0]  FsmState
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] SHOW    = 2'd2;

    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic              halt_q, halt_d;
    logic [7:0]        shift_q, shift_d;
    logic [11:0]       acc_q, acc_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [11:0]       bcd_q, bcd_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [1:0]        digit_q, digit_d;
    logic [6:0]        seg_q, seg_d;
    logic [2:0]        en_q, en_d;

    logic              halt_rise;
    logic [11:0]       acc_adj;
    logic [19:0]       wide_shift;
    logic [3:0]        cur_nibble;
    logic              cur_blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        halt_d     = Halt;
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        halt_rise  = Halt & ~halt_q;
        acc_adj    = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};
        wide_shift = {acc_adj, shift_q} << 1;

        case (state_q)
            IDLE, SHOW: begin
                if (halt_rise) begin
                    shift_d = Result;
                    acc_d   = 12'd0;
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                // Halt edges here are deliberately dropped, not queued.
                acc_d   = wide_shift[19:8];
                shift_d = wide_shift[7:0];
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    bcd_d   = wide_shift[19:8];
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = SHOW;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scan_d  = scan_q + SCAN_W'(1);
        digit_d = digit_q;
        if (scan_q == SCAN_LAST) begin
            scan_d  = '0;
            digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end

        // Display is computed from next-cycle values so the registered outputs line up with digit_q.
        case (digit_d)
            2'd1:    cur_nibble = bcd_d[7:4];
            2'd2:    cur_nibble = bcd_d[11:8];
            default: cur_nibble = bcd_d[3:0];
        endcase
        case (digit_d)
            2'd1:    cur_blank = (bcd_d[11:8] == 4'd0) && (bcd_d[7:4] == 4'd0);
            2'd2:    cur_blank = (bcd_d[11:8] == 4'd0);
            default: cur_blank = 1'b0;
        endcase

        seg_d = 7'd0;
        en_d  = 3'b000;
        if (valid_d && !cur_blank) begin
            seg_d = seg_of(cur_nibble);
            en_d  = 3'b001 << digit_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            halt_q  <= 1'b0;
            shift_q <= 8'd0;
            acc_q   <= 12'd0;
            cnt_q   <= 3'd0;
            bcd_q   <= 12'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            scan_q  <= '0;
            digit_q <= 2'd0;
            seg_q   <= 7'd0;
            en_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            scan_q  <= scan_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
        end
    end

    assign Bcd      = bcd_q;
    assign Valid    = valid_q;
    assign Busy     = busy_q;
    assign Seg      = seg_q;
    assign DigitEn  = en_q;
    assign FsmState = state_q;

endmodule

// File: tb/tb_gcd_result_display.sv
// Directed bench for gcd_result_display: table of results with hand-computed BCD and segment
// expectations, plus hand-written sequences for Halt filtering and reset abort.
module tb_gcd_result_display;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic [7:0]  result;
    logic [11:0] bcd;
    logic        valid;
    logic        busy;
    logic [6:0]  seg;
    logic [2:0]  digit_en;
    logic [1:0]  fsm_state;

    gcd_result_display #(.SCAN_CYCLES(S)) dut (
        .Clock(clk), .Reset(rst_n), .Halt(halt), .Result(result),
        .Bcd(bcd), .Valid(valid), .Busy(busy), .Seg(seg),
        .DigitEn(digit_en), .FsmState(fsm_state)
    );

    always #5 clk = ~clk;

    // Enabled edges since the last reset edge; sets the expected scan slot.
    int k = 0;
    always @(posedge clk) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    typedef struct {
        logic [7:0]  result;
        logic [11:0] bcd;
        logic [6:0]  seg_one;
        logic [6:0]  seg_ten;
        logic [6:0]  seg_hun;
        logic [2:0]  en_mask;
    } vec_t;

    vec_t vecs[10];
    int errors = 0;
    int checks = 0;
    logic [11:0] exp_bcd;
    logic        exp_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_seg"}, seg, 0);
        check({name, "_en"}, digit_en, 0);
        check({name, "_bcd"}, bcd, 0);
        check({name, "_valid"}, valid, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    task automatic scan_check(input vec_t v, input int n);
        int idx;
        logic [2:0] e_en;
        logic [6:0] e_seg;
        for (int i = 0; i < n; i++) begin
            idx = (k / S) % 3;
            e_en = v.en_mask[idx] ? (3'b001 << idx) : 3'b000;
            case (idx)
                1:       e_seg = v.seg_ten;
                2:       e_seg = v.seg_hun;
                default: e_seg = v.seg_one;
            endcase
            if (e_en == 3'b000) e_seg = 7'h00;
            check("scan_en", digit_en, e_en);
            check("scan_seg", seg, e_seg);
            @(negedge clk);
        end
    endtask

    // Entered at the negedge just after capture edge E.
    task automatic run_conv(input vec_t v);
        int busy_cnt = 0;
        check("busy_after_capture", busy, 1);
        for (int i = 0; i < 20 && busy; i++) begin
            busy_cnt++;
            check("state_convert", fsm_state, 1);
            check("hold_bcd", bcd, exp_bcd);
            check("hold_valid", valid, exp_valid);
            @(negedge clk);
        end
        check("busy_cycles", busy_cnt, 8);
        exp_bcd   = v.bcd;
        exp_valid = 1'b1;
        check("bcd", bcd, exp_bcd);
        check("valid", valid, 1);
        check("busy_done", busy, 0);
        check("state_show", fsm_state, 2);
        scan_check(v, 3 * S);
    endtask

    task automatic launch(input logic [7:0] r);
        @(negedge clk);
        result = r;
        halt   = 1'b1;
        @(negedge clk);
        halt   = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'd255, 12'h255, 7'h6D, 7'h6D, 7'h5B, 3'b111};
        vecs[1] = '{8'd7,   12'h007, 7'h07, 7'h00, 7'h00, 3'b001};
        vecs[2] = '{8'd0,   12'h000, 7'h3F, 7'h00, 7'h00, 3'b001};
        vecs[3] = '{8'd100, 12'h100, 7'h3F, 7'h3F, 7'h06, 3'b111};
        vecs[4] = '{8'd9,   12'h009, 7'h6F, 7'h00, 7'h00, 3'b001};
        vecs[5] = '{8'd10,  12'h010, 7'h3F, 7'h06, 7'h00, 3'b011};
        vecs[6] = '{8'd199, 12'h199, 7'h6F, 7'h6F, 7'h06, 3'b111};
        vecs[7] = '{8'd58,  12'h058, 7'h7F, 7'h6D, 7'h00, 3'b011};
        vecs[8] = '{8'd163, 12'h163, 7'h4F, 7'h7D, 7'h06, 3'b111};
        vecs[9] = '{8'd200, 12'h200, 7'h3F, 7'h3F, 7'h5B, 3'b111};

        rst_n = 1'b0; halt = 1'b0; result = 8'd0;
        exp_bcd = 12'h000; exp_valid = 1'b0;

        // Reset and idle with Halt low.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset_state", fsm_state, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_all_zero("idle");
            check("idle_state", fsm_state, 0);
        end

        for (int i = 0; i < 9; i++) begin
            launch(vecs[i].result);
            run_conv(vecs[i]);
        end

        // Halt toggling and Result change during CONVERT are ignored; held-high Halt never retriggers.
        @(negedge clk);
        result = 8'd42; halt = 1'b1;
        @(negedge clk); halt = 1'b0;
        @(negedge clk); halt = 1'b1; result = 8'd99;
        @(negedge clk); halt = 1'b0;
        @(negedge clk); halt = 1'b1;
        begin
            int busy_cnt = 0;
            for (int i = 0; i < 20 && busy; i++) begin
                busy_cnt++;
                @(negedge clk);
            end
            check("glitch_busy_cycles", busy_cnt, 5);
        end
        check("glitch_bcd", bcd, 12'h042);
        for (int i = 0; i < 50; i++) begin
            check("held_halt_busy", busy, 0);
            check("held_halt_bcd", bcd, 12'h042);
            @(negedge clk);
        end
        halt = 1'b0;
        exp_bcd = 12'h042;
        scan_check('{8'd42, 12'h042, 7'h5B, 7'h66, 7'h00, 3'b011}, 3 * S);

        // Reset at E+4 aborts conversion and clears the shown result.
        launch(8'd200);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        check("abort_state", fsm_state, 0);
        rst_n = 1'b1;
        exp_bcd = 12'h000; exp_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_all_zero("post_abort");
        end

        // Halt already high at the first enabled edge after reset starts a capture.
        rst_n = 1'b0; halt = 1'b1; result = 8'd200;
        repeat (2) @(negedge clk);
        check_all_zero("reset2");
        rst_n = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        run_conv(vecs[9]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gcd_result_display.md
# gcd_result_display

Downstream output stage for `EC2_microprocessor`. It captures the processor's 8-bit `Output` when `Halt` rises and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed three-digit seven-segment display with leading-zero blanking. The display holds the last result until a new `Halt` rising edge arrives.

## Interface
- `SCAN_CYCLES`, default 50000: clock cycles each digit stays lit per scan slot; legal range ≥1.
- `Clock`  in  1  sole clock; all state updates on posedge.
- `Reset`  in  1  synchronous, active-low; sampled on posedge `Clock`.
- `Halt`  in  1  processor halt flag; a rising edge marks `Result` valid.
- `Result`  in  8  processor `Output`, unsigned 0..255.
- `Bcd`  out  12  last converted value: hundreds [11:8], tens [7:4], ones [3:0].
- `Valid`  out  1  high once at least one conversion has completed since reset.
- `Busy`  out  1  high while a conversion is in progress.
- `Seg`  out  7  segment drive, active-high; bit0=a … bit6=g.
- `DigitEn`  out  3  one-hot digit enable, active-high; bit0=ones, bit1=tens, bit2=hundreds.

## Operation
- State register `halt_q` holds the previous `Halt` sample. Rising edge = `Halt`=1 and `halt_q`=0.
- FSM states:
  - IDLE: no result yet.
  - CONVERT: shifting.
  - SHOW: result displayed.
- IDLE or SHOW, on rising edge: latch `Result` into the shift register, clear the BCD accumulator and the 3-bit shift counter, set `Busy`=1, go to CONVERT.
- CONVERT, each cycle:
  - Add 3 to every accumulator nibble ≥5.
  - Shift {accumulator, shift register} left by 1.
  - Increment the counter.
- On the 8th shift: write the accumulator to `Bcd`, set `Valid`=1 and `Busy`=0, go to SHOW.
- `Halt` edges during CONVERT are ignored (not queued). `Halt` held high never retriggers.
- During reconversion from SHOW, `Bcd`, `Valid` and the display keep the previous value until the new result commits.
- Scan logic:
  - The scan counter runs freely from 0 to `SCAN_CYCLES`-1.
  - On wrap, the digit index advances 0→1→2→0.
  - The scan runs in every state.
- Digit output:
  - `Valid`=0: `DigitEn`=000, `Seg`=0.
  - Otherwise `DigitEn` is one-hot for the current index and `Seg` is the pattern for that `Bcd` nibble.
- Segment patterns, 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
- Blanking, which sets both `DigitEn`=000 and `Seg`=0 for that slot:
  - Hundreds is blanked when it is 0.
  - Tens is blanked when hundreds and tens are both 0.
  - Ones is never blanked.

## Timing
- Reset (`Reset`=0 at a posedge) sets, at that edge: `Seg`=0, `DigitEn`=0, `Bcd`=0, `Valid`=0, `Busy`=0, FSM=IDLE, `halt_q`=0, scan counter=0, digit index=0.
- Reset mid-conversion aborts it. A previously valid result is also cleared.
- If `Halt` is already 1 on the first enabled edge after reset, it counts as a rising edge and starts a capture.
- Capture edge E: `Result` is sampled at E and `Busy`=1 after E.
- Shifts occur at E+1 … E+8.
- After E+8: `Bcd` is updated, `Valid`=1, `Busy`=0. Latency is 8 cycles and `Busy` is high for exactly 8 cycles.
- A new edge is accepted from E+9 (state SHOW) onward.
- All outputs are registered and change only on posedge `Clock`.
- Each digit slot lasts exactly `SCAN_CYCLES` cycles. A full frame is 3·`SCAN_CYCLES` cycles.

## Test plan
1. Reset for 2 cycles, `Halt`=0 for 20 cycles → all outputs 0 and `DigitEn` stays 000.
2. `SCAN_CYCLES`=4, `Result`=255, `Halt` 0→1 → `Busy` high 8 cycles, then `Bcd`=12'h255 and `Valid`=1. Scan shows, 4 cycles each: `DigitEn`=001/`Seg`=6D, `DigitEn`=010/`Seg`=6D, `DigitEn`=100/`Seg`=5B.
3. `Result`=7 (gcd 21,14) → `Bcd`=12'h007. Ones slot shows `DigitEn`=001/`Seg`=07. Tens and hundreds slots show `DigitEn`=000/`Seg`=0.
4. `Result`=0 → `Bcd`=0 and `Valid`=1. Ones slot shows `Seg`=3F. Then, from SHOW, `Result`=100 with a new rising edge → old digits stay for 8 cycles, then `Bcd`=12'h100 and the tens slot shows 3F (not blanked).
5. Rising edge with `Result`=42, then `Halt` toggled and `Result` changed to 99 during CONVERT → `Bcd`=12'h042. `Halt` held high for 50 cycles afterwards → no further `Busy` pulse.
6. `Reset`=0 at cycle E+4 of a conversion → all outputs 0 on the next cycle and `Valid` stays 0 until a new rising edge after reset release.
